// File: rtl/peripheral_bin2bcd_gen.sv
// Memory-mapped binary-to-BCD converter with generic width/digit count.
// Sequential double-dabble engine converts one operand bit per clock.
module peripheral_bin2bcd_gen #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_input,
    input  logic        chip_select,
    input  logic [4:0]  address,
    input  logic        read,
    input  logic        write,
    output logic [31:0] data_output
);

    localparam int RW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [4:0] ADDR_OPERAND = 5'h04;
    localparam logic [4:0] ADDR_CONTROL = 5'h08;
    localparam logic [4:0] ADDR_START   = 5'h0C;
    localparam logic [4:0] ADDR_STATUS  = 5'h10;
    localparam logic [4:0] ADDR_RES_LO  = 5'h14;
    localparam logic [4:0] ADDR_RES_HI  = 5'h18;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] operand;
    logic             signed_mode;
    logic [WIDTH-1:0] magnitude;
    logic [RW-1:0]    shift_reg;
    logic [RW-1:0]    bcd_adj;
    logic [RW-1:0]    shift_next;
    logic [CW-1:0]    bit_count;
    logic [RW-1:0]    result;
    logic [63:0]      result_ext;
    logic             done;
    logic             negative;
    logic             overflow;
    logic             busy;
    logic             write_en;
    logic             read_en;
    logic             start_req;
    logic             last_shift;
    logic [31:0]      status;
    logic             unused_inputs;

    assign write_en   = chip_select & write;
    assign read_en    = chip_select & read;
    assign start_req  = write_en && (address == ADDR_START) && data_input[0];
    assign last_shift = (state == SHIFT) && (bit_count == CW'(WIDTH - 1));
    assign busy       = (state != IDLE);
    assign unused_inputs = ^data_input;

    // Add-3 correction on every digit that would reach 10 or more after doubling.
    always_comb begin
        bcd_adj = shift_reg;
        for (int d = 0; d < DIGITS; d++) begin
            if (shift_reg[4*d +: 4] >= 4'd5)
                bcd_adj[4*d +: 4] = shift_reg[4*d +: 4] + 4'd3;
        end
        shift_next = {bcd_adj[RW-2:0], magnitude[WIDTH-1]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_req) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Register file and conversion datapath; a completion on the same edge as a
    // status read leaves done set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            operand     <= '0;
            signed_mode <= 1'b0;
            magnitude   <= '0;
            shift_reg   <= '0;
            bit_count   <= '0;
            result      <= '0;
            done        <= 1'b0;
            negative    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (write_en && (address == ADDR_OPERAND))
                operand <= data_input[WIDTH-1:0];
            if (write_en && (address == ADDR_CONTROL))
                signed_mode <= data_input[0];
            if (read_en && (address == ADDR_STATUS))
                done <= 1'b0;

            case (state)
                LOAD: begin
                    if (signed_mode && operand[WIDTH-1]) begin
                        magnitude <= ~operand + WIDTH'(1);
                        negative  <= 1'b1;
                    end else begin
                        magnitude <= operand;
                        negative  <= 1'b0;
                    end
                    shift_reg <= '0;
                    overflow  <= 1'b0;
                    bit_count <= '0;
                end
                SHIFT: begin
                    shift_reg <= shift_next;
                    magnitude <= {magnitude[WIDTH-2:0], 1'b0};
                    bit_count <= bit_count + CW'(1);
                    if (bcd_adj[RW-1])
                        overflow <= 1'b1;
                    if (last_shift) begin
                        result <= shift_next;
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign status     = {28'd0, overflow, negative, busy, done};
    assign result_ext = {{(64 - RW){1'b0}}, result};

    always_comb begin
        data_output = 32'd0;
        if (read_en) begin
            case (address)
                ADDR_STATUS: data_output = status;
                ADDR_RES_LO: data_output = result_ext[31:0];
                ADDR_RES_HI: data_output = result_ext[63:32];
                default:     data_output = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_bin2bcd_gen.sv
// Directed bench for peripheral_bin2bcd_gen: three instances cover the
// 16/5, 32/10 and 16/4 width/digit configurations.
module tb_peripheral_bin2bcd_gen;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_input;
    logic [2:0]  cs;
    logic [4:0]  address;
    logic        read;
    logic        write;
    logic [31:0] dout_a, dout_b, dout_c;
    logic [31:0] rd;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    peripheral_bin2bcd_gen #(.WIDTH(16), .DIGITS(5)) u_a (
        .clock(clock), .reset(reset), .data_input(data_input), .chip_select(cs[0]),
        .address(address), .read(read), .write(write), .data_output(dout_a));

    peripheral_bin2bcd_gen #(.WIDTH(32), .DIGITS(10)) u_b (
        .clock(clock), .reset(reset), .data_input(data_input), .chip_select(cs[1]),
        .address(address), .read(read), .write(write), .data_output(dout_b));

    peripheral_bin2bcd_gen #(.WIDTH(16), .DIGITS(4)) u_c (
        .clock(clock), .reset(reset), .data_input(data_input), .chip_select(cs[2]),
        .address(address), .read(read), .write(write), .data_output(dout_c));

    function automatic logic [31:0] dout_sel(input int sel);
        case (sel)
            0:       return dout_a;
            1:       return dout_b;
            default: return dout_c;
        endcase
    endfunction

    task automatic bus_idle();
        cs = '0; read = 1'b0; write = 1'b0; address = '0; data_input = '0;
    endtask

    // One write strobe spanning exactly one rising edge.
    task automatic applyStimulus(input int sel, input logic [4:0] addr, input logic [31:0] data);
        @(negedge clock);
        cs = '0; cs[sel] = 1'b1; write = 1'b1; address = addr; data_input = data;
        @(negedge clock);
        bus_idle();
    endtask

    // Read strobe held across a rising edge (status reads clear done).
    task automatic bus_read(input int sel, input logic [4:0] addr, output logic [31:0] data);
        @(negedge clock);
        cs = '0; cs[sel] = 1'b1; read = 1'b1; address = addr;
        #1 data = dout_sel(sel);
        @(negedge clock);
        bus_idle();
    endtask

    // Combinational look at the read port without letting a clock edge see the strobe.
    task automatic bus_peek(input int sel, input logic [4:0] addr, output logic [31:0] data);
        cs = '0; cs[sel] = 1'b1; read = 1'b1; address = addr;
        #1 data = dout_sel(sel);
        #1 bus_idle();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus_idle();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        $display("[TB] reset state");
        bus_peek(0, 5'h10, rd); checkOutput("reset_status", rd, 32'h0);
        bus_peek(0, 5'h14, rd); checkOutput("reset_result", rd, 32'h0);
        @(negedge clock);
        cs = '0; read = 1'b1; address = 5'h10;
        #1 checkOutput("no_cs_read", dout_a, 32'h0);
        #1 bus_idle();

        $display("[TB] unsigned 0xCAFE with latency");
        applyStimulus(0, 5'h04, 32'h0000CAFE);
        applyStimulus(0, 5'h0C, 32'h1);
        bus_peek(0, 5'h10, rd); checkOutput("a_busy_start", rd, 32'h2);
        repeat (16) @(negedge clock);
        bus_peek(0, 5'h10, rd); checkOutput("a_busy_e16", rd, 32'h2);
        @(negedge clock);
        bus_peek(0, 5'h10, rd); checkOutput("a_done_e17", rd, 32'h1);
        bus_read(0, 5'h14, rd); checkOutput("a_cafe_lo", rd, 32'h00051966);
        bus_read(0, 5'h18, rd); checkOutput("a_cafe_hi", rd, 32'h0);
        bus_read(0, 5'h10, rd); checkOutput("a_status_1", rd, 32'h1);
        bus_read(0, 5'h10, rd); checkOutput("a_status_clr", rd, 32'h0);

        $display("[TB] signed mode");
        applyStimulus(0, 5'h08, 32'h1);
        applyStimulus(0, 5'h04, 32'h0000CAFE);
        applyStimulus(0, 5'h0C, 32'h1);
        repeat (17) @(negedge clock);
        bus_read(0, 5'h14, rd); checkOutput("a_scafe_res", rd, 32'h00013570);
        bus_read(0, 5'h10, rd); checkOutput("a_scafe_stat", rd, 32'h5);
        applyStimulus(0, 5'h04, 32'h00008000);
        applyStimulus(0, 5'h0C, 32'h1);
        repeat (17) @(negedge clock);
        bus_read(0, 5'h14, rd); checkOutput("a_s8000_res", rd, 32'h00032768);
        bus_read(0, 5'h10, rd); checkOutput("a_s8000_stat", rd, 32'h5);

        $display("[TB] start and operand write while busy");
        applyStimulus(0, 5'h08, 32'h0);
        applyStimulus(0, 5'h04, 32'h000000FF);
        applyStimulus(0, 5'h0C, 32'h1);
        bus_peek(0, 5'h14, rd); checkOutput("a_busy_oldres", rd, 32'h00032768);
        applyStimulus(0, 5'h04, 32'h00000001);
        applyStimulus(0, 5'h0C, 32'h1);
        repeat (17) @(negedge clock);
        bus_read(0, 5'h14, rd); checkOutput("a_ff_res", rd, 32'h00000255);
        bus_read(0, 5'h10, rd); checkOutput("a_ff_stat", rd, 32'h1);
        bus_read(0, 5'h10, rd); checkOutput("a_ff_stat_clr", rd, 32'h0);
        applyStimulus(0, 5'h0C, 32'h1);
        repeat (17) @(negedge clock);
        bus_read(0, 5'h14, rd); checkOutput("a_one_res", rd, 32'h00000001);

        $display("[TB] simultaneous read and write");
        @(negedge clock);
        cs = 3'b001; read = 1'b1; write = 1'b1; address = 5'h04; data_input = 32'h63;
        #1 checkOutput("a_rw_dout", dout_a, 32'h0);
        @(negedge clock);
        bus_idle();
        applyStimulus(0, 5'h0C, 32'h1);
        repeat (17) @(negedge clock);
        bus_read(0, 5'h14, rd); checkOutput("a_rw_res", rd, 32'h00000099);
        bus_peek(0, 5'h1C, rd); checkOutput("a_unmapped", rd, 32'h0);

        $display("[TB] reset mid-conversion");
        applyStimulus(0, 5'h04, 32'h00001234);
        applyStimulus(0, 5'h0C, 32'h1);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        bus_peek(0, 5'h10, rd); checkOutput("a_rst_status", rd, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        bus_peek(0, 5'h10, rd); checkOutput("a_post_rst_st", rd, 32'h0);
        bus_peek(0, 5'h14, rd); checkOutput("a_post_rst_res", rd, 32'h0);
        applyStimulus(0, 5'h04, 32'h00001234);
        applyStimulus(0, 5'h0C, 32'h1);
        repeat (17) @(negedge clock);
        bus_read(0, 5'h14, rd); checkOutput("a_1234_res", rd, 32'h00004660);
        bus_read(0, 5'h10, rd); checkOutput("a_1234_stat", rd, 32'h1);

        $display("[TB] 32-bit, 10 digits");
        applyStimulus(1, 5'h04, 32'hFFFFFFFF);
        applyStimulus(1, 5'h0C, 32'h1);
        bus_peek(1, 5'h10, rd); checkOutput("b_busy_start", rd, 32'h2);
        repeat (32) @(negedge clock);
        bus_peek(1, 5'h10, rd); checkOutput("b_busy_e32", rd, 32'h2);
        @(negedge clock);
        bus_peek(1, 5'h10, rd); checkOutput("b_done_e33", rd, 32'h1);
        bus_read(1, 5'h14, rd); checkOutput("b_res_lo", rd, 32'h94967295);
        bus_read(1, 5'h18, rd); checkOutput("b_res_hi", rd, 32'h00000042);

        $display("[TB] 16-bit, 4 digits overflow boundary");
        applyStimulus(2, 5'h04, 32'h0000270F);
        applyStimulus(2, 5'h0C, 32'h1);
        repeat (17) @(negedge clock);
        bus_read(2, 5'h14, rd); checkOutput("c_9999_res", rd, 32'h00009999);
        bus_read(2, 5'h10, rd); checkOutput("c_9999_stat", rd, 32'h1);
        applyStimulus(2, 5'h04, 32'h00002710);
        applyStimulus(2, 5'h0C, 32'h1);
        repeat (17) @(negedge clock);
        bus_read(2, 5'h14, rd); checkOutput("c_10000_res", rd, 32'h00000000);
        bus_read(2, 5'h10, rd); checkOutput("c_10000_stat", rd, 32'h9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
